// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, fetches one word from
// instruction memory over a req/ready handshake, presents it on IR with a
// one-cycle IL strobe, then waits for the control unit's done pulse (with an
// optional PC redirect) before fetching again.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   done,
    input  logic                   pc_load,
    input  logic [ADDR_WIDTH-1:0]  pc_target,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ready,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] IR,
    output logic                   IL,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic [15:0]            instr_count,
    output logic [1:0]             fetch_state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StIssue = 2'd2,
        StExec  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [15:0]            count_q, count_d;

    // State, PC, instruction and issue-count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            count_q <= count_d;
        end
    end

    // Next-state logic; PC only moves in ISSUE (increment) and EXEC (redirect),
    // which keeps mem_addr stable for the whole of FETCH.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                // A started fetch always completes, regardless of run.
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                pc_d    = pc_q + ADDR_WIDTH'(1);
                count_d = count_q + 16'd1;
                state_d = StExec;
            end
            StExec: begin
                if (done) begin
                    if (pc_load) pc_d = pc_target;
                    state_d = run ? StFetch : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state only; mem_addr is wired to pc.
    always_comb begin
        mem_req     = (state_q == StFetch);
        IL          = (state_q == StIssue);
        fetch_state = state_q;
        pc          = pc_q;
        mem_addr    = pc_q;
        IR          = ir_q;
        instr_count = count_q;
    end

endmodule
